// File: rtl/uart_tx.sv
// UART transmitter: serialises one byte per accepted request into a
// start / 8 data (LSB first) / optional parity / 1-2 stop bit frame.
module uart_tx #(
  parameter int CLKS_PER_BIT = 10416,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_en,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);
  localparam logic          PAR_INIT  = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          par_q, par_d;
  logic          tx_q, tx_d;
  logic          ready_q, ready_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          bit_end;

  assign bit_end = (cnt_q == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Outputs are computed one cycle ahead so every port comes straight off a flop.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    par_d   = par_q;
    tx_d    = tx_q;
    ready_d = ready_q;
    busy_d  = busy_q;
    done_d  = done_q;

    case (state_q)
      S_IDLE: begin
        cnt_d   = '0;
        tx_d    = 1'b1;
        ready_d = 1'b1;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        if (tx_en && tx_start) begin
          shreg_d = tx_data;
          par_d   = 1'b0;
          idx_d   = '0;
          state_d = S_START;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
          ready_d = 1'b0;
        end
      end

      S_START, S_DATA, S_PARITY, S_STOP: begin
        if (!bit_end) begin
          cnt_d = cnt_q + 1'b1;
        end else begin
          cnt_d = '0;
          case (state_q)
            S_START: begin
              state_d = S_DATA;
              idx_d   = '0;
              tx_d    = shreg_q[0];
              shreg_d = shreg_q >> 1;
              par_d   = par_q ^ shreg_q[0];
            end
            S_DATA: begin
              if (idx_q == 3'd7) begin
                idx_d = '0;
                if (PARITY_EN != 0) begin
                  state_d = S_PARITY;
                  tx_d    = par_q ^ PAR_INIT;
                end else begin
                  state_d = S_STOP;
                  tx_d    = 1'b1;
                end
              end else begin
                idx_d   = idx_q + 3'd1;
                tx_d    = shreg_q[0];
                shreg_d = shreg_q >> 1;
                par_d   = par_q ^ shreg_q[0];
              end
            end
            S_PARITY: begin
              state_d = S_STOP;
              idx_d   = '0;
              tx_d    = 1'b1;
            end
            default: begin
              // idx doubles as the stop-bit counter
              if (idx_q == STOP_LAST) begin
                state_d = S_DONE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                ready_d = 1'b0;
              end else begin
                idx_d = idx_q + 3'd1;
              end
            end
          endcase
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
        ready_d = 1'b1;
        busy_d  = 1'b0;
        done_d  = 1'b0;
      end

      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
        ready_d = 1'b1;
        busy_d  = 1'b0;
        done_d  = 1'b0;
      end
    endcase
  end

  assign tx       = tx_q;
  assign tx_ready = ready_q;
  assign tx_busy  = busy_q;
  assign tx_done  = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench: three transmitter configurations share one stimulus
// stream; a frame model queues expected frames, a monitor checks the line.
module tb_uart_tx;
  localparam int NI = 3;

  function automatic int f_cpb(int g);
    case (g) 0: return 4; 1: return 4; default: return 3; endcase
  endfunction
  function automatic int f_pen(int g);
    case (g) 0: return 0; default: return 1; endcase
  endfunction
  function automatic int f_odd(int g);
    case (g) 2: return 1; default: return 0; endcase
  endfunction
  function automatic int f_stop(int g);
    case (g) 1: return 2; default: return 1; endcase
  endfunction
  function automatic int f_nbits(int g);
    return 1 + 8 + f_pen(g) + f_stop(g);
  endfunction

  // Whole frame as a bit vector, bit 0 first on the line; unused tail stays 1.
  function automatic logic [11:0] f_frame(int g, logic [7:0] d);
    logic [11:0] f;
    f = '1;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[1+i] = d[i];
    if (f_pen(g) != 0) f[9] = (^d) ^ (f_odd(g) != 0);
    return f;
  endfunction

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tx_en = 1'b0;
  logic tx_start = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic [NI-1:0] tx_w, rdy_w, busy_w, done_w;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    uart_tx #(
      .CLKS_PER_BIT(f_cpb(g)),
      .PARITY_EN   (f_pen(g)),
      .PARITY_ODD  (f_odd(g)),
      .STOP_BITS   (f_stop(g))
    ) u_dut (
      .clk     (clk),
      .rst     (rst),
      .tx_en   (tx_en),
      .tx_start(tx_start),
      .tx_data (tx_data),
      .tx      (tx_w[g]),
      .tx_ready(rdy_w[g]),
      .tx_busy (busy_w[g]),
      .tx_done (done_w[g])
    );
  end

  // Reference model: decides acceptances from the frame-length rule alone.
  logic [11:0] q [NI][$];
  int cyc = 0;
  int free_at [NI];
  initial for (int g = 0; g < NI; g++) free_at[g] = 0;

  always @(posedge clk) begin
    for (int g = 0; g < NI; g++) begin
      if (rst) free_at[g] = cyc + 1;
      else if (tx_en && tx_start && cyc >= free_at[g]) begin
        q[g].push_back(f_frame(g, tx_data));
        free_at[g] = cyc + f_nbits(g) * f_cpb(g) + 2;
      end
    end
    cyc++;
  end

  // Monitor: compares {tx,ready,busy,done} every cycle on the falling edge.
  logic rst_d = 1'b1;
  always @(posedge clk) rst_d <= rst;

  int nchk = 0;
  int nfail = 0;
  bit act [NI];
  int t [NI];
  logic [11:0] cur [NI];
  bit drain_req = 1'b0;
  bit drain_ok = 1'b0;
  int drain_cnt = 0;
  logic [3:0] got_v, exp_v;
  string nm;
  bit all_idle;

  initial for (int g = 0; g < NI; g++) begin act[g] = 1'b0; t[g] = 0; cur[g] = '1; end

  always @(negedge clk) begin
    for (int g = 0; g < NI; g++) begin
      got_v = {tx_w[g], rdy_w[g], busy_w[g], done_w[g]};
      if (rst_d) begin
        nm = "reset";
        exp_v = 4'b1100;
        act[g] = 1'b0;
        q[g].delete();
      end else begin
        if (!act[g] && q[g].size() > 0) begin
          cur[g] = q[g].pop_front();
          act[g] = 1'b1;
          t[g] = 0;
        end
        if (act[g]) begin
          nm = "frame";
          if (t[g] < f_nbits(g) * f_cpb(g))
            exp_v = {cur[g][t[g] / f_cpb(g)], 1'b0, 1'b1, 1'b0};
          else if (t[g] == f_nbits(g) * f_cpb(g))
            exp_v = 4'b1001;
          else begin
            exp_v = 4'b1100;
            act[g] = 1'b0;
          end
          t[g]++;
        end else begin
          nm = "idle";
          exp_v = 4'b1100;
        end
      end
      nchk++;
      if (got_v !== exp_v) begin
        nfail++;
        $display("FAIL %s inst%0d cyc=%0d t=%0d {tx,ready,busy,done} got %b want %b",
                 nm, g, cyc, t[g], got_v, exp_v);
      end
    end
    if (drain_req && !drain_ok) begin
      all_idle = 1'b1;
      for (int g = 0; g < NI; g++) if (act[g] || q[g].size() > 0) all_idle = 1'b0;
      drain_cnt++;
      if (all_idle) drain_ok = 1'b1;
      else if (drain_cnt > 300) begin
        nchk++;
        nfail++;
        $display("FAIL drain: frames still pending after %0d cycles, want 0 pending", drain_cnt);
        drain_ok = 1'b1;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pulse(input logic [7:0] d, input int gap);
    tx_data = d; tx_start = 1'b1;
    tick(1);
    tx_start = 1'b0;
    tick(gap);
  endtask

  initial begin
    tick(3);
    rst = 1'b0;
    tx_en = 1'b1;
    tick(100);

    pulse(8'hA5, 60);
    pulse(8'h07, 60);

    // start held high: back-to-back frames, data changes mid-frame
    tx_data = 8'h3C; tx_start = 1'b1;
    tick(10);
    tx_data = 8'hC3;
    tick(70);
    tx_data = 8'($urandom);
    tick(60);
    tx_start = 1'b0;
    tick(60);

    // disabled: no frame
    tx_en = 1'b0; tx_start = 1'b1;
    tick(5);
    tx_start = 1'b0;
    tick(10);

    // enable dropped at data bit 3: frame finishes, nothing new starts
    tx_en = 1'b1;
    pulse(8'h5A, 16);
    tx_en = 1'b0; tx_start = 1'b1;
    tick(60);
    tx_start = 1'b0; tx_en = 1'b1;
    tick(5);

    // reset during data bit 4, then an immediate new request
    pulse(8'h96, 21);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    pulse(8'hE1, 60);

    for (int i = 0; i < 3000; i++) begin
      tx_en    = ($urandom_range(0, 9) != 0);
      tx_start = ($urandom_range(0, 3) == 0);
      tx_data  = 8'($urandom);
      rst      = ($urandom_range(0, 399) == 0);
      tick(1);
    end
    rst = 1'b0; tx_start = 1'b0; tx_en = 1'b1;

    drain_req = 1'b1;
    for (int i = 0; i < 400 && !drain_ok; i++) @(negedge clk);
    if (!drain_ok) begin
      $display("FAIL drain_handshake: monitor gave no drain result, want one within 400 cycles");
      $fatal(1, "drain did not complete");
    end
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule
